// File: rtl/vga_frame_scanout.sv
// VGA scanout: timing generator, SRAM line fetcher with scroll, 4-word
// FIFO and byte unpacker feeding the palette one index per clock.
module vga_frame_scanout #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 32,
  parameter int PREFETCH = 8
) (
  input  logic        Clk,
  input  logic        Reset_L,
  input  logic        Enable,
  input  logic [9:0]  HScrollValue,
  input  logic [9:0]  VScrollValue,
  output logic        Sram_Req,
  output logic [17:0] Sram_AddressOut,
  input  logic        Sram_Grant,
  input  logic [15:0] Sram_DataIn,
  output logic        HSync_L,
  output logic        VSync_L,
  output logic        Blank_L,
  output logic [7:0]  PixelIndex,
  output logic        Underflow
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int NEED0   = (H_ACTIVE + 1) / 2;
  localparam int NEED1   = (H_ACTIVE + 2) / 2;
  localparam int WW      = $clog2(NEED1 + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_PF   = HW'(H_TOTAL - PREFETCH);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [WW-1:0] NEED0_W = WW'(NEED0);
  localparam logic [WW-1:0] NEED1_W = WW'(NEED1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} fstate_e;

  // ---------------- timing counters ----------------
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d, vnext;
  logic          h_wrap, v_wrap, active, pix_en, restart;
  logic [8:0]    fy_new;
  logic          vscroll_unused;

  assign h_wrap  = (hcnt_q == H_LAST);
  assign v_wrap  = (vcnt_q == V_LAST);
  assign vnext   = v_wrap ? '0 : vcnt_q + 1'b1;
  assign hcnt_d  = h_wrap ? '0 : hcnt_q + 1'b1;
  assign vcnt_d  = h_wrap ? vnext : vcnt_q;
  assign active  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign pix_en  = active && Enable;
  // Prefetch point of the line before an active line; any fetch still
  // running for the previous line is abandoned so each line starts clean.
  assign restart = Enable && (hcnt_q == H_PF) && (vnext < V_ACT);
  assign fy_new  = 9'(vnext) + VScrollValue[8:0];
  assign vscroll_unused = VScrollValue[9];

  // Pixel clock raster position
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // ---------------- FIFO + fetcher state ----------------
  fstate_e       state_q, state_d;
  logic [9:0]    fx_q, fx_d;
  logic [8:0]    fy_q, fy_d;
  logic          skip_q, skip_d, sel_q, rvalid_q, req_c;
  logic [WW-1:0] words_q, words_d, words_inc, need;
  logic [15:0]   mem_q [4];
  logic [1:0]    wr_q, rd_q;
  logic [2:0]    cnt_q, cnt_next;
  logic          fifo_empty, push, pop;
  logic [15:0]   head;

  assign fifo_empty = (cnt_q == 3'd0);
  assign head       = mem_q[rd_q];
  assign pop        = pix_en && !fifo_empty && sel_q;
  // Returned word is kept only while enabled and not being flushed
  assign push       = (state_q == WAIT) && rvalid_q && Enable && !restart;
  assign cnt_next   = cnt_q + {2'b0, push} - {2'b0, pop};
  assign need       = skip_q ? NEED1_W : NEED0_W;
  assign words_inc  = words_q + 1'b1;

  assign Sram_Req        = req_c;
  assign Sram_AddressOut = {fy_q, fx_q[9:1]};

  // Fetcher next-state: request, wait for data, throttle on FIFO space
  always_comb begin
    state_d = state_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    skip_d  = skip_q;
    words_d = words_q;
    req_c   = 1'b0;
    case (state_q)
      REQ: begin
        if (!Enable) state_d = IDLE;
        else begin
          req_c = 1'b1;
          if (Sram_Grant) state_d = WAIT;
        end
      end
      WAIT: begin
        if (!Enable) state_d = IDLE;
        else begin
          if (push) begin
            fx_d    = fx_q + 10'd2;
            words_d = words_inc;
          end
          if (push && (words_inc == need)) state_d = IDLE;
          else if (cnt_next < 3'd4)        state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (restart) begin
      state_d = REQ;
      fx_d    = HScrollValue & 10'h3FE;
      fy_d    = fy_new;
      skip_d  = HScrollValue[0];
      words_d = '0;
    end
  end

  // Fetcher registers, return tracking and FIFO pointers
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q  <= IDLE;
      fx_q     <= '0;
      fy_q     <= '0;
      skip_q   <= 1'b0;
      words_q  <= '0;
      rvalid_q <= 1'b0;
      sel_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      fx_q     <= fx_d;
      fy_q     <= fy_d;
      skip_q   <= skip_d;
      words_q  <= words_d;
      rvalid_q <= req_c && Sram_Grant && !restart;
      if (restart) begin
        sel_q <= HScrollValue[0];
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (pix_en) sel_q <= ~sel_q;
        if (push)   wr_q  <= wr_q + 1'b1;
        if (pop)    rd_q  <= rd_q + 1'b1;
        cnt_q <= cnt_next;
      end
    end
  end

  // FIFO storage
  always_ff @(posedge Clk) begin
    if (push) mem_q[wr_q] <= Sram_DataIn;
  end

  // ---------------- registered video outputs ----------------
  logic       hs_q, vs_q, blank_q, und_q;
  logic       hs_d, vs_d, und_d;
  logic [7:0] pix_q, pix_d;

  assign hs_d  = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
  assign vs_d  = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
  assign pix_d = (pix_en && !fifo_empty) ? (sel_q ? head[7:0] : head[15:8]) : 8'd0;
  // Sticky starvation flag, cleared as VSync_L goes low
  assign und_d = (vs_q && !vs_d) ? 1'b0 : (und_q || (pix_en && fifo_empty));

  // Output stage keeps pixel, blank and syncs aligned
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      pix_q   <= 8'd0;
      und_q   <= 1'b0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= pix_en;
      pix_q   <= pix_d;
      und_q   <= und_d;
    end
  end

  assign HSync_L    = hs_q;
  assign VSync_L    = vs_q;
  assign Blank_L    = blank_q;
  assign PixelIndex = pix_q;
  assign Underflow  = und_q;
endmodule

// File: tb/tb_vga_frame_scanout.sv
// Directed bench for vga_frame_scanout with a small raster (16 x 5).
// Cycle index c counts clocks since reset release; the pixel of (frame f,
// line v, column h) is c = f*80 + v*16 + h and is visible at cyc = c+1.
module tb_vga_frame_scanout;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [9:0]  hscr, vscr;
  logic        req, grant, hold;
  logic [17:0] addr;
  logic [15:0] rdata;
  logic        hs, vs, blank, und;
  logic [7:0]  pix;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [17:0] gq [$];

  logic [7:0] exp_s0  [8] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04};
  logic [7:0] exp_h3  [8] = '{8'h02, 8'h02, 8'h03, 8'h03, 8'h04, 8'h04, 8'h05, 8'h05};
  logic [7:0] exp_wr  [8] = '{8'hFF, 8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03};

  vga_frame_scanout #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .PREFETCH(8)
  ) dut (
    .Clk(clk), .Reset_L(rst_n), .Enable(en),
    .HScrollValue(hscr), .VScrollValue(vscr),
    .Sram_Req(req), .Sram_AddressOut(addr), .Sram_Grant(grant),
    .Sram_DataIn(rdata),
    .HSync_L(hs), .VSync_L(vs), .Blank_L(blank),
    .PixelIndex(pix), .Underflow(und)
  );

  always #5 clk = ~clk;

  // SRAM model: grants unless held, data one cycle after grant
  assign grant = req & ~hold;
  always @(posedge clk) rdata <= {addr[7:0], addr[7:0] + 8'd1};
  always @(posedge clk) if (rst_n && req && grant) gq.push_back(addr);

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs"},   hs, 1);
    chk({tag, "_vs"},   vs, 1);
    chk({tag, "_blk"},  blank, 0);
    chk({tag, "_pix"},  pix, 0);
    chk({tag, "_req"},  req, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_und"},  und, 0);
  endtask

  initial begin
    int nhs, nvs, nbl;
    rst_n = 1'b1; en = 1'b1; hscr = '0; vscr = '0; hold = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk_reset_vals("rst");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Frame 0 line 0 had no prefetch: starved
    wait_cyc(1);
    chk("f0_und", und, 1);
    chk("f0_pix", pix, 0);

    // Frame 1 line 0, scroll 0
    wait_cyc(72); gq.delete();
    for (int h = 0; h < 8; h++) begin
      wait_cyc(80 + h + 1);
      chk($sformatf("s0_px%0d", h), pix, exp_s0[h]);
    end
    chk("s0_nreq", gq.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("s0_addr%0d", i), gq[i], i);
    chk("s0_und", und, 0);
    chk("s0_blk", blank, 1);

    // Sync / blank counts over frame 2
    nhs = 0; nvs = 0; nbl = 0;
    for (int c = 160; c < 240; c++) begin
      wait_cyc(c + 1);
      if (!hs) nhs++;
      if (!vs) nvs++;
      if (blank) nbl++;
    end
    chk("hs_low", nhs, 10);
    chk("vs_low", nvs, 16);
    chk("blank_hi", nbl, 16);

    // HScroll=3, VScroll=1 on frame 4 line 0
    wait_cyc(241); hscr = 10'd3; vscr = 10'd1;
    wait_cyc(312); gq.delete();
    for (int h = 0; h < 8; h++) begin
      wait_cyc(320 + h + 1);
      chk($sformatf("h3_px%0d", h), pix, exp_h3[h]);
    end
    chk("h3_nreq", gq.size(), 5);
    chk("h3_addr0", gq[0], {9'd1, 9'd1});
    chk("h3_addr4", gq[4], {9'd1, 9'd5});

    // VScroll=511 on line 1 -> fy 0; HScroll=1022 wraps x
    wait_cyc(330); hscr = 10'd1022; vscr = 10'd511;
    wait_cyc(408); gq.delete();
    for (int h = 0; h < 8; h++) begin
      wait_cyc(416 + h + 1);
      chk($sformatf("wr_px%0d", h), pix, exp_wr[h]);
    end
    chk("wr_nreq", gq.size(), 4);
    chk("wr_addr0", gq[0], {9'd0, 9'd511});
    chk("wr_addr1", gq[1], {9'd0, 9'd0});

    // Grant withheld across frame 6 line 0
    wait_cyc(425); hscr = '0; vscr = '0;
    wait_cyc(472); hold = 1'b1;
    wait_cyc(480);
    chk("st_und_before", und, 0);
    wait_cyc(481);
    chk("st_und_set", und, 1);
    chk("st_pix0", pix, 0);
    chk("st_blk0", blank, 1);
    wait_cyc(488);
    chk("st_pix7", pix, 0);
    wait_cyc(492); hold = 1'b0;
    wait_cyc(528);
    chk("st_und_held", und, 1);
    chk("st_vs_hi", vs, 1);
    wait_cyc(529);
    chk("st_vs_lo", vs, 0);
    chk("st_und_clr", und, 0);

    // Reset while a fetch is outstanding (frame 7 line 0 fetch)
    wait_cyc(555);
    chk("mr_req", req, 1);
    chk("mr_addr", addr, {9'd0, 9'd1});
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mr");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int h = 0; h < 8; h++) begin
      wait_cyc(16 + h + 1);
      chk($sformatf("pr_px%0d", h), pix, exp_s0[h]);
    end

    // Enable low: blanking, no requests, resume at later prefetch point
    wait_cyc(70); en = 1'b0;
    wait_cyc(73);
    chk("en_req", req, 0);
    wait_cyc(84);
    chk("en_blk", blank, 0);
    chk("en_pix", pix, 0);
    wait_cyc(90); en = 1'b1;
    wait_cyc(161);
    chk("en_res_blk", blank, 1);
    chk("en_res_px0", pix, 0);
    wait_cyc(162);
    chk("en_res_px1", pix, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
